// File: rtl/event_accumulator_if.sv
// Event accumulator port bundle: source pulses, crossing handshake and status.
// The slave side is the accumulator; the master side drives it.
interface event_accumulator_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 in_event;
    logic                 clear;
    logic                 xing_ready;
    logic                 xing_event;
    logic [CNT_WIDTH-1:0] pending;
    logic                 overflow;
    logic                 overflow_clr;
    logic                 busy;

    modport master (
        output in_event,
        output clear,
        output xing_ready,
        output overflow_clr,
        input  xing_event,
        input  pending,
        input  overflow,
        input  busy
    );

    modport slave (
        input  in_event,
        input  clear,
        input  xing_ready,
        input  overflow_clr,
        output xing_event,
        output pending,
        output overflow,
        output busy
    );
endinterface

// File: rtl/event_accumulator.sv
// Counts event pulses and replays them one at a time into the event
// clock-crossing stage, honouring its ready with a fire/guard cadence.
module event_accumulator #(
    parameter int CNT_WIDTH = 8
) (
    input logic                clk,
    input logic                reset,
    event_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRE  = 2'd1,
        GUARD = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state_q;
    state_t               state_d;
    logic [CNT_WIDTH-1:0] pending_q;
    logic                 overflow_q;
    logic                 inc;
    logic                 dec;
    logic                 drop;

    assign inc  = bus.in_event & ~bus.clear;
    assign drop = inc & ~dec & (pending_q == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // clear wins over launching a new pulse in the same cycle
    always_comb begin
        state_d = state_q;
        dec     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((pending_q != '0) && bus.xing_ready && !bus.clear) begin
                    state_d = FIRE;
                    dec     = 1'b1;
                end
            end
            FIRE:    state_d = GUARD;
            GUARD:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            unique case (1'b1)
                bus.clear:         pending_q <= '0;
                inc & ~dec & ~drop: pending_q <= pending_q + CNT_ONE;
                dec & ~inc:        pending_q <= pending_q - CNT_ONE;
                default:           pending_q <= pending_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (bus.overflow_clr) begin
            overflow_q <= 1'b0;
        end
    end

    assign bus.xing_event = (state_q == FIRE);
    assign bus.pending    = pending_q;
    assign bus.overflow   = overflow_q;
    assign bus.busy       = (pending_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_event_accumulator.sv
// Randomized and directed checks of event_accumulator against a
// count-and-cooldown reference model.
module tb_event_accumulator;

    localparam int W   = 3;
    localparam int MAX = (1 << W) - 1;

    logic clk;
    logic reset;

    event_accumulator_if #(.CNT_WIDTH(W)) bus ();

    event_accumulator #(.CNT_WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // model: events owed, cycles until the next launch decision, sticky drop
    int m_cnt  = 0;
    int m_cool = 0;
    bit m_ovf  = 1'b0;
    bit m_evt  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_cool = 0;
        m_ovf  = 1'b0;
        m_evt  = 1'b0;
    endtask

    task automatic model_step(input bit i, input bit c, input bit r, input bit oc);
        bit fire;
        bit drop;
        fire = (m_cool == 0) && (m_cnt > 0) && r && !c;
        drop = !c && i && !fire && (m_cnt == MAX);
        if (c) m_cnt = 0;
        else if (!drop) m_cnt = m_cnt + int'(i) - int'(fire);
        if (drop) m_ovf = 1'b1;
        else if (oc) m_ovf = 1'b0;
        m_evt = fire;
        if (fire) m_cool = 2;
        else if (m_cool > 0) m_cool = m_cool - 1;
    endtask

    task automatic tick(input bit i, input bit c, input bit r, input bit oc);
        bus.in_event     = i;
        bus.clear        = c;
        bus.xing_ready   = r;
        bus.overflow_clr = oc;
        @(posedge clk);
        model_step(i, c, r, oc);
        #1;
    endtask

    task automatic do_reset();
        bus.in_event     = 1'b0;
        bus.clear        = 1'b0;
        bus.xing_ready   = 1'b0;
        bus.overflow_clr = 1'b0;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            chk("xing_event", int'(bus.xing_event), int'(m_evt));
            chk("pending", int'(bus.pending), m_cnt);
            chk("overflow", int'(bus.overflow), int'(m_ovf));
            chk("busy", int'(bus.busy), int'((m_cnt != 0) || (m_cool != 0)));
        end
    end

    initial begin
        int pulses;
        int last;
        int low;
        bit rdy;

        reset = 1'b0;
        do_reset();
        chk("rst_pending", int'(bus.pending), 0);
        chk("rst_xing", int'(bus.xing_event), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_busy", int'(bus.busy), 0);
        cmp_en = 1'b1;

        // single event latency
        repeat (3) tick(0, 0, 1, 0);
        tick(1, 0, 1, 0);
        chk("single_pend1", int'(bus.pending), 1);
        chk("single_noevt", int'(bus.xing_event), 0);
        tick(0, 0, 1, 0);
        chk("single_evt", int'(bus.xing_event), 1);
        chk("single_pend0", int'(bus.pending), 0);
        tick(0, 0, 1, 0);
        chk("single_guard_busy", int'(bus.busy), 1);
        chk("single_one_pulse", int'(bus.xing_event), 0);
        tick(0, 0, 1, 0);
        chk("single_idle_busy", int'(bus.busy), 0);

        // burst under backpressure, crossing-style ready handshake
        do_reset();
        repeat (5) tick(1, 0, 0, 0);
        chk("burst_pend5", int'(bus.pending), 5);
        chk("burst_noevt", int'(bus.xing_event), 0);
        tick(0, 0, 1, 0);
        chk("burst_fire", int'(bus.xing_event), 1);
        chk("burst_pend4", int'(bus.pending), 4);
        pulses = 1;
        last   = 0;
        low    = 2;
        for (int k = 1; k < 40; k++) begin
            rdy = (low == 0);
            if (low > 0) low--;
            tick(0, 0, rdy, 0);
            if (bus.xing_event) begin
                pulses++;
                checks++;
                if (k - last < 3) begin
                    errors++;
                    $display("FAIL burst_spacing: got %0d expected >=3", k - last);
                end
                last = k;
                low  = 2;
            end
        end
        chk("burst_total", pulses, 5);
        chk("burst_drained", int'(bus.pending), 0);

        // saturation and sticky overflow
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            tick(1, 0, 0, 0);
            if (k == 7) chk("sat_no_ovf", int'(bus.overflow), 0);
            if (k == 8) chk("sat_ovf", int'(bus.overflow), 1);
        end
        chk("sat_pend", int'(bus.pending), MAX);
        tick(0, 0, 0, 1);
        chk("sat_ovf_clr", int'(bus.overflow), 0);
        tick(1, 0, 0, 1);
        chk("sat_set_wins", int'(bus.overflow), 1);
        chk("sat_pend_hold", int'(bus.pending), MAX);

        // increment and decrement together
        do_reset();
        repeat (3) tick(1, 0, 0, 0);
        tick(1, 0, 1, 0);
        chk("incdec_pend", int'(bus.pending), 3);
        chk("incdec_evt", int'(bus.xing_event), 1);
        tick(0, 0, 0, 0);
        chk("incdec_once", int'(bus.xing_event), 0);

        // clear during GUARD
        do_reset();
        repeat (5) tick(1, 0, 0, 0);
        tick(0, 0, 1, 0);
        chk("clr_fire", int'(bus.xing_event), 1);
        tick(0, 0, 0, 0);
        tick(1, 1, 1, 0);
        chk("clr_pend", int'(bus.pending), 0);
        pulses = 0;
        repeat (8) begin
            tick(0, 0, 1, 0);
            if (bus.xing_event) pulses++;
        end
        chk("clr_no_more", pulses, 0);

        // async reset in the middle of FIRE
        do_reset();
        repeat (3) tick(1, 0, 0, 0);
        tick(0, 0, 1, 0);
        chk("arst_fire", int'(bus.xing_event), 1);
        chk("arst_pend2", int'(bus.pending), 2);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("arst_xing", int'(bus.xing_event), 0);
        chk("arst_pend", int'(bus.pending), 0);
        chk("arst_ovf", int'(bus.overflow), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pulses = 0;
        repeat (6) begin
            tick(0, 0, 1, 0);
            if (bus.xing_event) pulses++;
        end
        chk("arst_quiet", pulses, 0);

        // randomized traffic
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            tick($urandom_range(0, 99) < 55,
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 5);
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/event_accumulator.md
Name: event_accumulator

Overview:
- Single-clock event queue that sits directly upstream of the event clock-crossing stage, in the crossing's input-clock domain.
- Accepts event pulses at up to one per cycle and counts the ones not yet sent.
- Replays them one at a time as single-cycle pulses, and only when the crossing reports ready, so no event is lost to crossing backpressure.
- Reports the backlog depth and a sticky overflow flag.

Parameters:
CNT_WIDTH, 8, width of pending-event counter; maximum backlog is 2^CNT_WIDTH-1

Ports:
clk  input  1  clock; all signals synchronous to it
reset  input  1  asynchronous, active-high reset
in_event  input  1  one-cycle pulse per source event; may assert every cycle
clear  input  1  synchronous; discards the backlog
xing_ready  input  1  crossing stage ready to accept an event
xing_event  output  1  one-cycle event pulse to the crossing stage
pending  output  CNT_WIDTH  events accepted but not yet issued
overflow  output  1  sticky; an event was dropped because pending was saturated
overflow_clr  input  1  synchronous clear of overflow
busy  output  1  high when pending!=0 or state!=IDLE

Behaviour:
- Reset (async assert, sync deassert assumed from the reset tree): state=IDLE, xing_event=0, pending=0, overflow=0, busy=0.
- Reset mid-FIRE truncates the pulse. Reset must be coordinated with the crossing stage's input reset.
- FSM states:
  - IDLE: if pending!=0 and xing_ready, go to FIRE and decrement pending this cycle. Otherwise stay.
  - FIRE: xing_event=1 (registered, exactly one cycle). Xing_ready is ignored. Go to GUARD.
  - GUARD: one cycle. Xing_ready is ignored, which covers the cycle where the crossing's ready has not yet dropped. Go to IDLE.
- The minimum spacing between xing_event pulses is 3 cycles. Actual spacing is set by the round-trip time of xing_ready.
- Pending update each cycle: inc=in_event and no clear; dec=IDLE->FIRE transition.
  - pending_next = pending + inc - dec.
  - inc and dec in the same cycle: pending unchanged.
  - Saturation: if pending==2^CNT_WIDTH-1, inc=1 and dec=0, pending holds and overflow sets next cycle. The event is dropped.
- clear: pending<=0 next cycle and in_event that cycle is discarded. An in-progress FIRE/GUARD completes; the decrement already happened.
  - clear takes priority over the IDLE->FIRE decision: no FIRE entry in a clear cycle.
- overflow: set on a saturated drop, cleared by overflow_clr. Simultaneous set and clear: set wins.
- Latency: with idle FSM, pending=0 and xing_ready=1, an in_event in cycle N gives pending=1 in N+1 and xing_event=1 in N+2.
- in_event is never back-pressured. The accumulator never asserts xing_event unless xing_ready was high in the IDLE decision cycle.
- busy is combinational from state and pending.
- Widths: pending is unsigned CNT_WIDTH bits. The counter never wraps in either direction: a decrement is only possible when pending!=0.

Test Plan:
- Single event: reset, xing_ready=1, in_event at cycle 10 -> pending=1 at 11, xing_event=1 only at 12, pending=0 at 12, busy=0 at 14.
- Burst under backpressure: xing_ready=0, 5 consecutive in_event pulses -> pending=5, xing_event=0. Raise xing_ready -> FIRE within 1 cycle, pending=4. Toggle ready as the crossing model does -> exactly 5 pulses total, ≥3 cycles apart.
- Saturation with CNT_WIDTH=3: hold xing_ready=0, 9 in_event pulses -> pending=7, overflow=1 from the cycle after the 8th pulse. Then overflow_clr asserted alone -> overflow=0. overflow_clr coincident with another saturated drop -> overflow stays 1.
- Simultaneous increment and decrement: pending=3, xing_ready=1, in_event in the IDLE->FIRE cycle -> pending stays 3 and xing_event pulses once.
- Clear during GUARD with pending=4 and in_event=1 -> pending=0, the current pulse completes once, no further xing_event.
- Async reset asserted during FIRE with pending=2 -> xing_event, pending and overflow go 0 immediately without a clock edge. After release, no pulse until a new in_event.
